// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the cache miss/fill controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int unsigned BLOCK_WORDS       = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_BYTES        = 2;

endpackage

// File: rtl/dff.sv
// Generic register cell: async active-high reset to zero.
module dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/fill_counter.sv
// Clearable, enabled up-counter that saturates at MAX; state held in a dff cell.
module fill_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_next;

    // Clear wins over enable; hold once MAX is reached.
    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (enable && (count < W'(MAX)))
            count_next = count + W'(1);
    end

    dff #(.W(W)) u_count_q (
        .clk (clk),
        .rst (rst),
        .d   (count_next),
        .q   (count)
    );

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: issues one block of pipelined word reads, streams the
// returned words into the data array, then writes the tag.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = BLOCK_WORDS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    input  logic [DATA_W-1:0]                  memory_data,
    output logic                               fsm_busy,
    output logic                               mem_read_en,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_index,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               write_tag_array,
    output logic                               fill_done
);

    localparam int unsigned IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W      = IDX_W + 1;
    localparam int unsigned BLOCK_MASK = WORDS_PER_BLOCK * WORD_BYTES - 1;

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              start_fill;
    logic              issue_en;
    logic              recv_en;
    logic              last_word;

    assign start_fill = (state == IDLE) && miss_detected;
    assign issue_en   = (state == FILL) && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign recv_en    = (state == FILL) && memory_data_valid;
    assign last_word  = recv_en && (recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    // Control state and latched block base; new misses are only taken from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state <= FILL;
                        base  <= miss_address & ~ADDR_W'(BLOCK_MASK);
                    end
                end
                FILL: begin
                    if (last_word)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fill_counter #(.MAX(WORDS_PER_BLOCK), .W(CNT_W)) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_fill),
        .enable (issue_en),
        .count  (issue_cnt)
    );

    fill_counter #(.MAX(WORDS_PER_BLOCK), .W(CNT_W)) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_fill),
        .enable (recv_en),
        .count  (recv_cnt)
    );

    // Outputs follow state directly so the stall begins in the miss cycle.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_index  = '0;
        fill_data        = memory_data;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        if (state == FILL) begin
            fsm_busy         = 1'b1;
            mem_read_en      = issue_en;
            write_data_array = recv_en;
            fill_word_index  = recv_cnt[IDX_W-1:0];
            write_tag_array  = last_word;
            fill_done        = last_word;
            if (issue_en)
                memory_address = base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES);
        end else begin
            fsm_busy = miss_detected;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: transaction-level model plus a
// fixed-latency pipelined memory, with directed scenarios and literal checks.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_index;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic        fill_done;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_index   (fill_word_index),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit spur  = 1'b0;

    // Transaction model: pending block addresses and next expected slot.
    bit          m_fill;
    logic [15:0] m_base;
    logic [15:0] m_q[$];
    int          m_idx;

    // Memory: reads return LAT cycles later, in order.
    int          due_q[$];
    logic [15:0] maddr_q[$];

    // Per-scenario observation trackers.
    int          seg_n, t_rd, t_tags, t_done_at, t_rd_at_done, t_first_wr;
    logic [15:0] t_first_addr, t_last_addr, t_min_addr;
    bit          busy_h[128];
    bit          rd_h[128];

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic seg_start();
        seg_n = 0; t_rd = 0; t_tags = 0; t_done_at = -1; t_rd_at_done = -1;
        t_first_wr = -1; t_first_addr = 16'h0; t_last_addr = 16'h0; t_min_addr = 16'hFFFF;
        for (int i = 0; i < 128; i++) begin busy_h[i] = 1'b0; rd_h[i] = 1'b0; end
    endtask

    task automatic model_reset();
        m_fill = 1'b0; m_idx = 0; m_q.delete(); due_q.delete(); maddr_q.delete();
    endtask

    // One clock cycle: drive at negedge, check at +1, advance model after posedge.
    task automatic step();
        bit          e_busy, e_rd, e_wr, e_done, s_rd;
        logic [15:0] s_addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = memfn(maddr_q[0]);
        end
        if (spur) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end
        #1;
        e_busy = m_fill || miss_detected;
        e_rd   = m_fill && (m_q.size() > 0);
        e_wr   = m_fill && memory_data_valid;
        e_done = e_wr && (m_idx == 7);
        chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
        chk("mem_read_en", 32'(mem_read_en), 32'(e_rd));
        if (e_rd) chk("memory_address", 32'(memory_address), 32'(m_q[0]));
        chk("write_data_array", 32'(write_data_array), 32'(e_wr));
        if (e_wr) begin
            chk("fill_word_index", 32'(fill_word_index), 32'(m_idx));
            chk("fill_data", 32'(fill_data), 32'(memfn(m_base + 16'(2 * m_idx))));
        end
        chk("write_tag_array", 32'(write_tag_array), 32'(e_done));
        chk("fill_done", 32'(fill_done), 32'(e_done));

        busy_h[seg_n] = fsm_busy;
        rd_h[seg_n]   = mem_read_en;
        if (mem_read_en) begin
            if (t_rd == 0) t_first_addr = memory_address;
            t_last_addr = memory_address;
            if (memory_address < t_min_addr) t_min_addr = memory_address;
            t_rd++;
        end
        if (write_data_array && t_first_wr < 0) t_first_wr = int'(fill_word_index);
        if (write_tag_array) t_tags++;
        if (fill_done && t_done_at < 0) begin t_done_at = seg_n; t_rd_at_done = t_rd; end
        s_rd   = mem_read_en;
        s_addr = memory_address;

        @(posedge clk);
        if (!m_fill) begin
            if (miss_detected) begin
                m_fill = 1'b1;
                m_idx  = 0;
                m_base = miss_address & 16'hFFF0;
                m_q.delete();
                for (int i = 0; i < 8; i++) m_q.push_back(m_base + 16'(2 * i));
            end
        end else begin
            if (e_rd) void'(m_q.pop_front());
            if (e_wr) begin
                if (m_idx == 7) m_fill = 1'b0;
                else            m_idx++;
            end
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            void'(maddr_q.pop_front());
        end
        if (s_rd) begin
            due_q.push_back(cyc + LAT);
            maddr_q.push_back(s_addr);
        end
        cyc++;
        seg_n++;
        @(negedge clk);
    endtask

    task automatic run_miss(input logic [15:0] a, input int n);
        miss_detected = 1'b1; miss_address = a;
        step();
        miss_detected = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 32'd0);
        chk({tag, "_rd"},   32'(mem_read_en), 32'd0);
        chk({tag, "_addr"}, 32'(memory_address), 32'd0);
        chk({tag, "_wr"},   32'(write_data_array), 32'd0);
        chk({tag, "_idx"},  32'(fill_word_index), 32'd0);
        chk({tag, "_tag"},  32'(write_tag_array), 32'd0);
        chk({tag, "_done"}, 32'(fill_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
        memory_data_valid = 1'b0; memory_data = 16'h0;
        model_reset();
        seg_start();
        @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle with no miss.
        seg_start();
        repeat (20) step();
        chk("idle_reads", 32'(t_rd), 32'd0);

        // Basic fill at 0x1234.
        seg_start();
        run_miss(16'h1234, 19);
        begin
            int nb = 0;
            for (int i = 0; i < 20; i++) nb += int'(busy_h[i]);
            chk("fill1_busy_cycles", 32'(nb), 32'd13);
        end
        chk("fill1_first_addr", 32'(t_first_addr), 32'h1230);
        chk("fill1_last_addr",  32'(t_last_addr),  32'h123E);
        chk("fill1_reads",      32'(t_rd), 32'd8);
        chk("fill1_done_at",    32'(t_done_at), 32'd12);
        chk("fill1_first_idx",  32'(t_first_wr), 32'd0);
        chk("fill1_tags",       32'(t_tags), 32'd1);

        // Top-of-memory block must not wrap.
        seg_start();
        run_miss(16'hFFFA, 19);
        chk("wrap_first_addr", 32'(t_first_addr), 32'hFFF0);
        chk("wrap_last_addr",  32'(t_last_addr),  32'hFFFE);
        chk("wrap_min_addr",   32'(t_min_addr),   32'hFFF0);
        chk("wrap_reads",      32'(t_rd), 32'd8);

        // Miss held high: second fill begins only after fill_done.
        seg_start();
        miss_detected = 1'b1; miss_address = 16'h0040;
        repeat (16) step();
        miss_detected = 1'b0;
        repeat (25) step();
        chk("held_done_at",      32'(t_done_at), 32'd12);
        chk("held_reads_to_done", 32'(t_rd_at_done), 32'd8);
        chk("held_busy_after",   32'(busy_h[13]), 32'd1);
        chk("held_no_rd_at_13",  32'(rd_h[13]), 32'd0);
        chk("held_rd_at_14",     32'(rd_h[14]), 32'd1);
        chk("held_total_reads",  32'(t_rd), 32'd16);

        // Reset asserted while the third word is on the bus.
        seg_start();
        miss_detected = 1'b1; miss_address = 16'h0200;
        step();
        miss_detected = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (m_idx == 2 && due_q.size() > 0 && due_q[0] == cyc) break;
            step();
        end
        chk("abort_reached_word3", 32'(m_idx == 2 && due_q.size() > 0 && due_q[0] == cyc), 32'd1);
        memory_data_valid = 1'b1;
        memory_data       = (maddr_q.size() > 0) ? memfn(maddr_q[0]) : 16'h0;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        chk("abort_tag_after_edge", 32'(write_tag_array), 32'd0);
        chk("abort_tags_seen", 32'(t_tags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc++;

        seg_start();
        run_miss(16'h0100, 19);
        chk("post_abort_first_addr", 32'(t_first_addr), 32'h0100);
        chk("post_abort_first_idx",  32'(t_first_wr), 32'd0);
        chk("post_abort_done_at",    32'(t_done_at), 32'd12);
        chk("post_abort_tags",       32'(t_tags), 32'd1);

        // Spurious valid while idle.
        seg_start();
        spur = 1'b1;
        repeat (3) step();
        spur = 1'b0;
        chk("spur_writes", 32'(t_first_wr), 32'hFFFF_FFFF);
        seg_start();
        run_miss(16'h2000, 19);
        chk("spur_next_first_idx", 32'(t_first_wr), 32'd0);
        chk("spur_next_done_at",   32'(t_done_at), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
